irq_controller: RTL

//  Interrupt controller; drives the CPU interrupt-request side of the exception interface.
//  - Collects NUM_SRC asynchronous interrupt sources into pending bits.
//  - Arbitrates them by fixed priority and raises irq_req while the CPU interrupt enable is set.
//  - Holds one interrupt in service, from the CPU's irq_ack pulse until the CPU's rfi pulse.
//  - Software accesses it through a 4-word memory-mapped register window.

---
 rtl/irqc_pkg.sv | 20 ++
 rtl/irqc_sync_edge.sv | 30 +++
 rtl/irq_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/irqc_pkg.sv
// Shared constants and types for the interrupt controller: register offsets,
// controller state encoding and CAUSE register layout.
package irqc_pkg;

    localparam int REG_W           = 16;
    localparam int ID_W            = 4;
    localparam int CAUSE_VALID_BIT = 15;

    localparam logic [1:0] ADDR_PEND  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_CAUSE = 2'd2;
    localparam logic [1:0] ADDR_TRIG  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irqc_state_t;

endpackage

// File: rtl/irqc_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line, followed by a
// previous-value flop so a rising edge is reported for exactly one cycle.
module irqc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic level,
    output logic rise
);

    logic meta_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            meta_p0 <= src;
            sync_p1 <= meta_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller with a 4-word register window.
// Define IRQC_EDGE_CFG_EN to make TRIG writable (per-source level mode).
module irq_controller
    import irqc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cpu_ie,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               rfi,
    input  logic               bus_req,
    input  logic               bus_we,
    input  logic [1:0]         bus_addr,
    input  logic [REG_W-1:0]   bus_wdata,
    output logic [REG_W-1:0]   bus_rdata,
    output logic               bus_rvalid
);

    localparam int PAD_W = REG_W - NUM_SRC;

    irqc_state_t        state;
    logic [NUM_SRC-1:0] lvl, rise, pend, mask, trig, act;
    logic [NUM_SRC-1:0] pend_n, w1c, ack_clr, wdata_src;
    logic [ID_W-1:0]    winner, cause_id;
    logic               cause_valid, act_cur, ack_take, wr_en, rd_en;
    logic [REG_W-1:0]   rd_val;
    logic               unused_wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irqc_sync_edge u_sync (
            .clk   (clk),
            .rst   (rst),
            .src   (src[g]),
            .level (lvl[g]),
            .rise  (rise[g])
        );
    end

    assign wr_en        = bus_req & bus_we;
    assign rd_en        = bus_req & ~bus_we;
    assign wdata_src    = bus_wdata[NUM_SRC-1:0];
    assign unused_wdata = ^bus_wdata;
    assign act          = pend & mask;
    assign ack_take     = (state == REQ) && irq_ack;
    assign w1c          = (wr_en && bus_addr == ADDR_PEND) ? wdata_src : '0;

`ifdef IRQC_EDGE_CFG_EN
    always_ff @(posedge clk) begin
        if (rst)
            trig <= '0;
        else if (wr_en && bus_addr == ADDR_TRIG)
            trig <= wdata_src;
    end
`else
    assign trig = '0;
`endif

    // Lowest set index wins; act_cur tracks whether the latched request is still live.
    always_comb begin
        winner  = '0;
        act_cur = 1'b0;
        ack_clr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i])
                winner = ID_W'(i);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ID_W'(i) == irq_id) begin
                act_cur    = act[i];
                ack_clr[i] = ack_take;
            end
        end
    end

    // A new rising edge beats any clear landing in the same cycle.
    always_comb begin
        pend_n = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (trig[i])
                pend_n[i] = lvl[i];
            else
                pend_n[i] = rise[i] | (pend[i] & ~(w1c[i] | ack_clr[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= pend_n;
            if (wr_en && bus_addr == ADDR_MASK)
                mask <= wdata_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            irq_req     <= 1'b0;
            irq_id      <= '0;
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|act && cpu_ie) begin
                        state   <= REQ;
                        irq_req <= 1'b1;
                        irq_id  <= winner;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state       <= SERVICE;
                        irq_req     <= 1'b0;
                        cause_valid <= 1'b1;
                        cause_id    <= irq_id;
                    end else if (!act_cur) begin
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (rfi) begin
                        state       <= IDLE;
                        cause_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (bus_addr)
            ADDR_PEND:  rd_val = {{PAD_W{1'b0}}, pend};
            ADDR_MASK:  rd_val = {{PAD_W{1'b0}}, mask};
            ADDR_CAUSE: begin
                rd_val[CAUSE_VALID_BIT] = cause_valid;
                rd_val[ID_W-1:0]        = cause_id;
            end
            ADDR_TRIG:  rd_val = {{PAD_W{1'b0}}, trig};
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            bus_rvalid <= rd_en;
            if (rd_en)
                bus_rdata <= rd_val;
        end
    end

endmodule
